// File: rtl/maxpool_pkg.sv
// Shared constants and types for the SPPF max-pool window path.
package maxpool_pkg;

  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
  localparam int unsigned POOL_K       = 5;
  localparam int unsigned POOL_PAD     = 2;

  typedef enum logic [1:0] {
    S_RUN,
    S_PAD,
    S_WRAP
  } state_t;

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// One virtual-row delay line: the tap is the element pushed DEPTH steps earlier.
module maxpool_line_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_tap
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_mem[k] <= '0;
      end
    end else if (i_en) begin
      r_mem[0] <= i_data;
      for (int k = 1; k < int'(DEPTH); k++) begin
        r_mem[k] <= r_mem[k-1];
      end
    end
  end

  assign o_tap = r_mem[DEPTH-1];

endmodule

// File: rtl/maxpool5_window_gen.sv
// Streaming 5x5 window generator (stride 1, pad 2 with FP16 -inf) over a padded virtual raster.
module maxpool5_window_gen
  import maxpool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_W      = 20,
  parameter int unsigned IMG_H      = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH*25-1:0] out_window,
  output logic                     out_last
);

  localparam int unsigned VW   = IMG_W + 2;
  localparam int unsigned VH   = IMG_H + 2;
  localparam int unsigned XW   = idx_bits(VW);
  localparam int unsigned YW   = idx_bits(VH);
  localparam int unsigned NTAP = POOL_K - 1;
  localparam logic [DATA_WIDTH-1:0] PAD_VAL = DATA_WIDTH'(FP16_NEG_INF);

  logic [XW-1:0] r_x, w_x_d;
  logic [YW-1:0] r_y, w_y_d;
  state_t        r_state, w_state_d;

  logic w_real, w_stall, w_step, w_emit, w_last_pos;

  // w_chain[k] is the pixel k virtual rows above the current position, same column.
  logic [DATA_WIDTH-1:0] w_chain [POOL_K];
  logic [DATA_WIDTH-1:0] r_win   [POOL_K][POOL_K];
  logic [DATA_WIDTH-1:0] w_win_d [POOL_K][POOL_K];
  logic [POOL_K-1:0]     w_row_ok, w_col_ok;
  logic [DATA_WIDTH*25-1:0] w_masked, r_out_window;
  logic                     r_out_valid, r_out_last;

  assign w_real     = (r_state == S_RUN);
  assign w_last_pos = (r_state == S_WRAP);
  assign w_stall    = r_out_valid && !out_ready;
  assign w_step     = !w_stall && (w_real ? in_valid : 1'b1);
  assign in_ready   = w_real && !w_stall && !rst;
  assign w_emit     = w_step && (r_y >= YW'(POOL_PAD)) && (r_x >= XW'(POOL_PAD));
  assign w_chain[0] = w_real ? in_data : PAD_VAL;

  always_comb begin
    w_x_d     = r_x;
    w_y_d     = r_y;
    w_state_d = r_state;
    if (w_step) begin
      if (r_x == XW'(VW - 1)) begin
        w_x_d = '0;
        w_y_d = (r_y == YW'(VH - 1)) ? '0 : r_y + YW'(1);
      end else begin
        w_x_d = r_x + XW'(1);
      end
      if ((w_x_d < XW'(IMG_W)) && (w_y_d < YW'(IMG_H))) begin
        w_state_d = S_RUN;
      end else if ((w_x_d == XW'(VW - 1)) && (w_y_d == YW'(VH - 1))) begin
        w_state_d = S_WRAP;
      end else begin
        w_state_d = S_PAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_state <= S_RUN;
    end else begin
      r_x     <= w_x_d;
      r_y     <= w_y_d;
      r_state <= w_state_d;
    end
  end

  for (genvar g = 0; g < int'(NTAP); g++) begin : g_lb
    maxpool_line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (VW)
    ) u_lb (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_step),
      .i_data(w_chain[g]),
      .o_tap (w_chain[g+1])
    );
  end

  always_comb begin
    for (int i = 0; i < int'(POOL_K); i++) begin
      for (int j = 0; j < int'(POOL_K) - 1; j++) begin
        w_win_d[i][j] = r_win[i][j+1];
      end
      w_win_d[i][POOL_K-1] = w_chain[int'(POOL_K) - 1 - i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(POOL_K); i++) begin
        for (int j = 0; j < int'(POOL_K); j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_step) begin
      r_win <= w_win_d;
    end
  end

  // Source row is y-4+i and column x-4+j; compare with the offset added to stay non-negative.
  always_comb begin
    w_row_ok = '0;
    w_col_ok = '0;
    for (int i = 0; i < int'(POOL_K); i++) begin
      w_row_ok[i] = (int'(r_y) + i >= int'(POOL_K) - 1) &&
                    (int'(r_y) + i < int'(IMG_H) + int'(POOL_K) - 1);
      w_col_ok[i] = (int'(r_x) + i >= int'(POOL_K) - 1) &&
                    (int'(r_x) + i < int'(IMG_W) + int'(POOL_K) - 1);
    end
  end

  always_comb begin
    w_masked = '0;
    for (int i = 0; i < int'(POOL_K); i++) begin
      for (int j = 0; j < int'(POOL_K); j++) begin
        w_masked[DATA_WIDTH*(24 - 5*i - j) +: DATA_WIDTH] =
          (w_row_ok[i] && w_col_ok[j]) ? w_win_d[i][j] : PAD_VAL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_window <= '0;
    end else if (w_emit) begin
      r_out_valid  <= 1'b1;
      r_out_last   <= w_last_pos;
      r_out_window <= w_masked;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign out_window = r_out_window;

endmodule

// File: tb/tb_maxpool5_window_gen.sv
// Scoreboard bench: a 5x5 instance for directed/handshake cases and a 20x20 instance for the ramp.
module tb_maxpool5_window_gen;

  localparam int SW = 5;
  localparam int LW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic out_ready;

  logic in_valid_s, in_ready_s, out_valid_s, out_last_s;
  logic in_valid_l, in_ready_l, out_valid_l, out_last_l;
  logic [399:0] out_window_s, out_window_l;

  always #5 clk = ~clk;

  assign in_valid_s = in_valid && !sel;
  assign in_valid_l = in_valid && sel;

  maxpool5_window_gen #(.DATA_WIDTH(16), .IMG_W(SW), .IMG_H(SW)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_window(out_window_s),
    .out_last(out_last_s)
  );

  maxpool5_window_gen #(.DATA_WIDTH(16), .IMG_W(LW), .IMG_H(LW)) u_dut_l (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready_l), .in_data(in_data),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_window(out_window_l),
    .out_last(out_last_l)
  );

  typedef struct packed {
    logic [399:0] win;
    logic         last;
    logic         centre;
    logic [4:0]   k;
  } exp_t;

  exp_t q_s[$];
  exp_t q_l[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] img [LW][LW];
  bit gaps = 1'b0;
  bit rdy_toggle = 1'b0;
  bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int rdy_k = 0;
  bit prev_stall [2];
  logic [399:0] prev_win [2];
  logic prev_last [2];

  task automatic check(input string name, input logic [399:0] act, input logic [399:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [399:0] exp_window(input int r, input int c, input int h, input int w);
    logic [399:0] v;
    int rr, cc;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        rr = r - 2 + i;
        cc = c - 2 + j;
        v[16*(24-5*i-j) +: 16] = (rr >= 0 && rr < h && cc >= 0 && cc < w) ? img[rr][cc]
                                                                              : 16'hFC00;
      end
    end
    return v;
  endfunction

  function automatic bit fp16_gt(input logic [15:0] a, input logic [15:0] b);
    if (a[15] != b[15]) return b[15];
    if (!a[15]) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  task automatic mon(input int b, input logic v, input logic [399:0] w, input logic l);
    exp_t e;
    logic [15:0] mx;
    int pads;
    if (prev_stall[b]) begin
      check($sformatf("hold_valid_%0d", b), v, 1);
      check($sformatf("hold_window_%0d", b), w, prev_win[b]);
      check($sformatf("hold_last_%0d", b), l, prev_last[b]);
    end
    if (v && out_ready) begin
      if ((b == 0 && q_s.size() == 0) || (b == 1 && q_l.size() == 0)) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_window_%0d: got window %0h, required none", b, w);
      end else begin
        e = (b == 0) ? q_s.pop_front() : q_l.pop_front();
        check($sformatf("window_%0d", b), w, e.win);
        check($sformatf("last_%0d", b), l, e.last);
        if (e.centre) begin
          mx = 16'hFC00;
          pads = 0;
          for (int k = 0; k < 25; k++) begin
            if (w[16*k +: 16] == 16'hFC00) pads++;
            if (fp16_gt(w[16*k +: 16], mx)) mx = w[16*k +: 16];
          end
          check("window_max", mx, 16'h4200);
          if (e.k == 5'd0) check("pad_count_w0", pads, 16);
          if (e.k == 5'd12) check("pad_count_w12", pads, 0);
        end
      end
    end
    prev_stall[b] = v && !out_ready;
    prev_win[b]   = w;
    prev_last[b]  = l;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      mon(0, out_valid_s, out_window_s, out_last_s);
      mon(1, out_valid_l, out_window_l, out_last_l);
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) begin
        out_ready = rdy_pat[rdy_k % 4];
        rdy_k++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic send_px(input logic [15:0] d);
    int guard;
    bit acc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    acc      = 1'b0;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = sel ? in_ready_l : in_ready_s;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      $display("FAIL accept_timeout: got no in_ready in 500 cycles, required acceptance");
      $fatal(1, "pixel never accepted");
    end
  endtask

  // kind 0: 4000 with centre 4200, 1: constant val, 2: val + r*w + c
  task automatic send_frame(input int h, input int w, input int kind, input logic [15:0] val);
    exp_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        case (kind)
          0:       img[r][c] = (r == 2 && c == 2) ? 16'h4200 : 16'h4000;
          1:       img[r][c] = val;
          default: img[r][c] = val + 16'(r * w + c);
        endcase
      end
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.win    = exp_window(r, c, h, w);
        e.last   = (r == h - 1) && (c == w - 1);
        e.centre = (kind == 0);
        e.k      = 5'(r * w + c);
        if (sel) q_l.push_back(e);
        else q_s.push_back(e);
      end
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        send_px(img[r][c]);
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((q_s.size() != 0 || q_l.size() != 0) && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check(name, q_s.size() + q_l.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid_s, 0);
    check("reset_out_last", out_last_s, 0);
    check("reset_in_ready", in_ready_s, 0);
    check("reset_out_window", out_window_s, 0);
    check("reset_out_valid_l", out_valid_l, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Stall-free centre frame, then flush with in_valid low.
    send_frame(SW, SW, 0, 16'h0);
    begin
      int guard;
      bit seen;
      guard = 0;
      seen  = 1'b0;
      while (!seen && guard < 100) begin
        @(negedge clk);
        if (out_valid_s && out_last_s) seen = 1'b1;
        else check("in_ready_during_pad", in_ready_s, 0);
        guard++;
      end
      check("flush_reaches_last", seen, 1);
      @(posedge clk);
      #1;
    end
    wait_drain("drain_centre");

    // Same frame under output backpressure and input gaps.
    gaps = 1'b1;
    rdy_toggle = 1'b1;
    send_frame(SW, SW, 0, 16'h0);
    wait_drain("drain_stalled");
    gaps = 1'b0;
    rdy_toggle = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back frames with no idle input.
    send_frame(SW, SW, 1, 16'hBC00);
    send_frame(SW, SW, 1, 16'h4500);
    wait_drain("drain_b2b");

    // Abort mid-frame via reset.
    for (int k = 0; k < 7; k++) send_px(16'h7777);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid_s, 0);
    check("abort_out_last", out_last_s, 0);
    check("abort_in_ready", in_ready_s, 0);
    check("abort_out_window", out_window_s, 0);
    q_s.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(SW, SW, 2, 16'h3C00);
    wait_drain("drain_after_reset");

    // 20x20 ramp on the large instance.
    sel = 1'b1;
    @(posedge clk);
    #1;
    send_frame(LW, LW, 2, 16'h0000);
    wait_drain("drain_ramp");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
